// File: rtl/riscv_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_test_pkg
// Description : Shared types and constants for the riscv-tests pass/fail
//               monitor: FSM state encoding, watched register indices and
//               the magic values written by the test harness.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_test_pkg;

    // Monitor FSM state, explicitly 2 bits wide
    typedef logic [1:0] state_t;
    localparam state_t ST_RUN    = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    // Register-file indices used by the riscv-tests environment
    localparam logic [4:0] TESTNUM_REG = 5'd3;
    localparam logic [4:0] DONE_REG    = 5'd26;
    localparam logic [4:0] PASS_REG    = 5'd27;

    // Values signalling "test finished" and "test passed"
    localparam logic [31:0] DONE_VAL = 32'h1;
    localparam logic [31:0] PASS_VAL = 32'h1;

endpackage
`default_nettype wire

// File: rtl/riscv_test_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : riscv_test_sat_cnt
// Description : 32-bit up counter with synchronous clear and enable that
//               sticks at all-ones; o_max flags the saturated value.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_test_sat_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    output logic [31:0] o_count,
    output logic        o_max
);

    logic [31:0] r_count;

    assign o_max   = &r_count;
    assign o_count = r_count;

    // Count up while enabled, never wrapping past all-ones
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_max) begin
            r_count <= r_count + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/riscv_test_monitor.sv
`default_nettype none
// ============================================================================
// Module      : riscv_test_monitor
// Description : Snoops the core register-file write port, shadows x3 (test
//               number) and x27 (pass flag), and turns a write of 1 to x26
//               into sticky done/pass/fail verdicts after a settle window.
//               Optional cycle-budget timeout enabled by the macro
//               RISCV_TEST_MONITOR_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_test_monitor
    import riscv_test_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 10,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_we,
    input  logic [4:0]  reg_waddr,
    input  logic [31:0] reg_wdata,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [31:0] fail_testnum,
    output logic [31:0] cycle_count
);

    localparam logic [31:0] c_SETTLE_LOAD = 32'(SETTLE_CYCLES);

    state_t      r_state;
    logic [31:0] r_settle;
    logic [31:0] r_x3;
    logic [31:0] r_x27;
    logic        r_done;
    logic        r_pass;
    logic        r_fail;
    logic        r_timeout;
    logic [31:0] r_fail_testnum;

    logic        w_wr_testnum;
    logic        w_wr_pass;
    logic        w_trigger;
    logic        w_pass_now;
    logic        w_timeout_hit;
    logic        w_cnt_en;
    logic        w_cnt_max;
    logic [31:0] w_cycle_count;

    // x26 only matters as an event (the trigger); its value is never needed
    // afterwards, so only x3 and x27 keep a shadow copy.
    assign w_wr_testnum = reg_we && (reg_waddr == TESTNUM_REG);
    assign w_wr_pass    = reg_we && (reg_waddr == PASS_REG);
    assign w_trigger    = reg_we && (reg_waddr == DONE_REG) && (reg_wdata == DONE_VAL);
    assign w_pass_now   = (r_x27 == PASS_VAL);

`ifdef RISCV_TEST_MONITOR_TIMEOUT_EN
    assign w_timeout_hit = (w_cycle_count == 32'(TIMEOUT_CYCLES));
`else
    assign w_timeout_hit = 1'b0;
`endif

    // Cycle counter runs during RUN and SETTLE and freezes once the verdict is in
    assign w_cnt_en = (r_state != ST_DONE) && !w_cnt_max;

    riscv_test_sat_cnt u_cycle_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_en    (w_cnt_en),
        .o_count (w_cycle_count),
        .o_max   (w_cnt_max)
    );

    // Shadow the watched registers until the verdict is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x3  <= '0;
            r_x27 <= '0;
        end else if (r_state != ST_DONE) begin
            if (w_wr_testnum) r_x3  <= reg_wdata;
            if (w_wr_pass)    r_x27 <= reg_wdata;
        end
    end

    // Control FSM with registered verdict outputs; the verdict uses shadow
    // values from before the DONE edge, so a write on that edge is excluded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_settle       <= '0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_fail         <= 1'b0;
            r_timeout      <= 1'b0;
            r_fail_testnum <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // Trigger takes priority over a coincident timeout
                    if (w_trigger) begin
                        r_state  <= ST_SETTLE;
                        r_settle <= c_SETTLE_LOAD;
                    end else if (w_timeout_hit) begin
                        r_state        <= ST_DONE;
                        r_done         <= 1'b1;
                        r_fail         <= 1'b1;
                        r_timeout      <= 1'b1;
                        r_fail_testnum <= r_x3;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle == 32'd0) begin
                        r_state        <= ST_DONE;
                        r_done         <= 1'b1;
                        r_pass         <= w_pass_now;
                        r_fail         <= !w_pass_now;
                        r_fail_testnum <= w_pass_now ? 32'd0 : r_x3;
                    end else begin
                        r_settle <= r_settle - 32'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign done         = r_done;
    assign pass         = r_pass;
    assign fail         = r_fail;
    assign timeout      = r_timeout;
    assign fail_testnum = r_fail_testnum;
    assign cycle_count  = w_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_riscv_test_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_test_monitor
// Description : Self-checking bench for riscv_test_monitor. Directed
//               scenarios plus randomized register writes, every cycle
//               compared against an edge-indexed behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_test_monitor;

    localparam int S  = 10;
    localparam int TO = 50;
`ifdef RISCV_TEST_MONITOR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [31:0] fail_testnum;
    logic [31:0] cycle_count;

    always #5 clk = ~clk;

    riscv_test_monitor #(
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .reg_we       (reg_we),
        .reg_waddr    (reg_waddr),
        .reg_wdata    (reg_wdata),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .fail_testnum (fail_testnum),
        .cycle_count  (cycle_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edges counted since reset, edge of the trigger,
    // verdict computed from the rules once the settle window has elapsed.
    int          m_edge;
    int          m_trig;
    bit          m_done, m_pass, m_fail, m_to;
    logic [31:0] m_tn, m_cyc, m_x3, m_x27;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_edge = 0; m_trig = -1;
        m_done = 0; m_pass = 0; m_fail = 0; m_to = 0;
        m_tn = 0; m_cyc = 0; m_x3 = 0; m_x27 = 0;
    endtask

    task automatic model_edge(input logic we, input logic [4:0] a, input logic [31:0] d);
        bit trig;
        trig = we && (a == 5'd26) && (d == 32'd1);
        m_edge++;
        if (!m_done) begin
            if (m_trig >= 0 && m_edge == m_trig + S + 1) begin
                m_done = 1;
                m_pass = (m_x27 == 32'd1);
                m_fail = !m_pass;
                m_tn   = m_pass ? 32'd0 : m_x3;
            end else if (m_trig < 0 && trig) begin
                m_trig = m_edge;
            end else if (TO_EN && m_trig < 0 && m_cyc == TO) begin
                m_done = 1; m_fail = 1; m_to = 1; m_tn = m_x3;
            end
            if (we && a == 5'd3)  m_x3  = d;
            if (we && a == 5'd27) m_x27 = d;
            if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
        end
    endtask

    task automatic check_outputs();
        check_val("done",         {31'd0, done},    {31'd0, m_done});
        check_val("pass",         {31'd0, pass},    {31'd0, m_pass});
        check_val("fail",         {31'd0, fail},    {31'd0, m_fail});
        check_val("timeout",      {31'd0, timeout}, {31'd0, m_to});
        check_val("fail_testnum", fail_testnum,     m_tn);
        check_val("cycle_count",  cycle_count,      m_cyc);
    endtask

    task automatic step(input logic we, input logic [4:0] a, input logic [31:0] d);
        reg_we = we; reg_waddr = a; reg_wdata = d;
        @(posedge clk);
        model_edge(we, a, d);
        #1;
        reg_we = 1'b0; reg_waddr = '0; reg_wdata = '0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; reg_we = 1'b0; reg_waddr = '0; reg_wdata = '0;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        check_outputs();
    endtask

    initial begin
        rst = 1'b1; reg_we = 1'b0; reg_waddr = '0; reg_wdata = '0;
        repeat (2) @(posedge clk);

        // Reset state
        do_reset();

        // Pass sequence
        step(1'b1, 5'd27, 32'd1);
        step(1'b1, 5'd5, 32'hDEAD_BEEF);
        step(1'b1, 5'd26, 32'd1);
        idle(10);
        check_val("pass_not_yet", {31'd0, done}, 32'd0);
        idle(1);
        check_val("pass_done", {31'd0, done}, 32'd1);
        check_val("pass_flag", {31'd0, pass}, 32'd1);
        check_val("pass_tn", fail_testnum, 32'd0);
        idle(5);

        // Fail sequence with test number 7
        do_reset();
        step(1'b1, 5'd3, 32'd7);
        step(1'b1, 5'd27, 32'd0);
        step(1'b1, 5'd26, 32'd1);
        idle(12);
        check_val("fail_flag", {31'd0, fail}, 32'd1);
        check_val("fail_tn", fail_testnum, 32'd7);
        check_val("fail_to", {31'd0, timeout}, 32'd0);

        // Late pass: x27 written on the last included edge (T+10)
        do_reset();
        step(1'b1, 5'd3, 32'd4);
        step(1'b1, 5'd26, 32'd1);
        idle(9);
        step(1'b1, 5'd27, 32'd1);
        idle(3);
        check_val("late_pass", {31'd0, pass}, 32'd1);

        // Too late: x27 written on the DONE edge (T+11) is excluded
        do_reset();
        step(1'b1, 5'd3, 32'd9);
        step(1'b1, 5'd26, 32'd1);
        idle(10);
        step(1'b1, 5'd27, 32'd1);
        idle(3);
        check_val("late_fail", {31'd0, fail}, 32'd1);
        check_val("late_fail_tn", fail_testnum, 32'd9);

        // Non-trigger writes and x0 write; second trigger in SETTLE ignored
        do_reset();
        step(1'b1, 5'd26, 32'd2);
        step(1'b1, 5'd0, 32'd1);
        step(1'b1, 5'd26, 32'd0);
        idle(20);
        check_val("no_trigger", {31'd0, done}, 32'd0);
        step(1'b1, 5'd26, 32'd1);
        idle(4);
        step(1'b1, 5'd26, 32'd1);
        idle(8);

        // Reset during SETTLE, then a clean pass
        do_reset();
        step(1'b1, 5'd27, 32'd1);
        step(1'b1, 5'd26, 32'd1);
        idle(4);
        do_reset();
        check_val("rst_settle_done", {31'd0, done}, 32'd0);
        step(1'b1, 5'd27, 32'd1);
        step(1'b1, 5'd26, 32'd1);
        idle(12);
        check_val("rst_then_pass", {31'd0, pass}, 32'd1);

        // Randomized write traffic
        for (int it = 0; it < 10; it++) begin
            do_reset();
            for (int c = 0; c < 45; c++) begin
                int r;
                r = $urandom_range(0, 9);
                case (r)
                    0, 1, 2: step(1'b0, 5'($urandom_range(0, 31)), $urandom);
                    3:       step(1'b1, 5'($urandom_range(0, 31)), $urandom);
                    4:       step(1'b1, 5'd3, 32'($urandom_range(0, 255)));
                    5, 6:    step(1'b1, 5'd27, 32'($urandom_range(0, 2)));
                    7:       step(1'b1, 5'd26, 32'($urandom_range(0, 2)));
                    default: step(1'b1, 5'd26, 32'd1);
                endcase
            end
        end

        // Timeout budget: no trigger at all
        do_reset();
        step(1'b1, 5'd3, 32'd33);
`ifdef RISCV_TEST_MONITOR_TIMEOUT_EN
        idle(60);
        check_val("to_done", {31'd0, done}, 32'd1);
        check_val("to_flag", {31'd0, timeout}, 32'd1);
        check_val("to_tn", fail_testnum, 32'd33);
`else
        idle(1000);
        check_val("no_to_done", {31'd0, done}, 32'd0);
        check_val("no_to_flag", {31'd0, timeout}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
